// File: rtl/fan_ctrl_multi_if.sv
// Button/status bundle between the debounce front end and the fan controller.
// The controller uses the slave modport; the stimulus side uses master.
interface fan_ctrl_multi_if #(
    parameter int NCH   = 2,
    parameter int TMR_W = 16
);
    logic [NCH-1:0]   btn_speed;
    logic             btn_timer;
    logic [NCH-1:0]   pwm_out;
    logic [NCH*4-1:0] level_o;
    logic [1:0]       tmr_sel;
    logic [TMR_W-1:0] tmr_sec;
    logic             timeout;

    modport master (
        output btn_speed, btn_timer,
        input  pwm_out, level_o, tmr_sel, tmr_sec, timeout
    );

    modport slave (
        input  btn_speed, btn_timer,
        output pwm_out, level_o, tmr_sel, tmr_sec, timeout
    );
endinterface

// File: rtl/fan_ctrl_multi.sv
// Multi-channel fan/light controller: per-channel button-cycled level,
// soft-ramped duty, wrap-synchronised PWM, and a shared off-timer that
// forces every channel to level 0 when it expires.
module fan_ctrl_multi #(
    parameter int NCH        = 2,
    parameter int PWM_BITS   = 8,
    parameter int LEVELS     = 4,
    parameter int DUTY_STEP  = 85,
    parameter int PWM_DIV    = 4,
    parameter int RAMP_DIV   = 1000,
    parameter int CLK_HZ     = 100000000,
    parameter int TMR_STEP_S = 60,
    parameter int TMR_W      = 16
) (
    input logic             clk,
    input logic             reset_p,
    fan_ctrl_multi_if.slave bus
);
    localparam int PW = $clog2(PWM_DIV + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam int SW = $clog2(CLK_HZ + 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [3:0]          level    [NCH];
    logic [PWM_BITS-1:0] target   [NCH];
    logic [PWM_BITS-1:0] cur_duty [NCH];
    logic [PWM_BITS-1:0] eff_duty [NCH];
    logic [NCH-1:0]      pwm_q;

    logic [PW-1:0]       pwm_pre;
    logic [RW-1:0]       ramp_pre;
    logic [SW-1:0]       sec_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    state_t              state;
    logic [1:0]          tmr_sel;
    logic [1:0]          sel_inc;
    logic [TMR_W-1:0]    tmr_sec;
    logic                timeout;

    logic pwm_step, pwm_wrap, ramp_step, sec_tick, expire;

    // Strobes and per-channel target duty.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        pwm_step  = (pwm_pre == PW'(PWM_DIV - 1));
        pwm_wrap  = pwm_step && (pwm_cnt == '1);
        ramp_step = (ramp_pre == RW'(RAMP_DIV - 1));
        // A timer press restarts the second counter and swallows a coinciding tick.
        sec_tick  = (sec_cnt == SW'(CLK_HZ - 1)) && !bus.btn_timer;
        expire    = (state == RUN) && sec_tick && (tmr_sec == TMR_W'(1));
        sel_inc   = tmr_sel + 2'd1;
        for (int i = 0; i < NCH; i++) begin
            target[i] = PWM_BITS'(32'(level[i]) * DUTY_STEP);
        end
    end

    // Prescalers, shared PWM counter and one-second counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            pwm_pre  <= '0;
            ramp_pre <= '0;
            pwm_cnt  <= '0;
            sec_cnt  <= '0;
        end else begin
            pwm_pre  <= pwm_step ? '0 : pwm_pre + 1'b1;
            ramp_pre <= ramp_step ? '0 : ramp_pre + 1'b1;
            if (pwm_step) pwm_cnt <= pwm_cnt + 1'b1;
            if (bus.btn_timer || sec_tick) sec_cnt <= '0;
            else                           sec_cnt <= sec_cnt + 1'b1;
        end
    end

    // Per-channel level, duty ramp, period-latched duty and registered PWM pin.
    // NOTE: these small per-channel arrays are flops, not RAM, so they are reset like any register.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            for (int i = 0; i < NCH; i++) begin
                level[i]    <= '0;
                cur_duty[i] <= '0;
                eff_duty[i] <= '0;
            end
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (expire)
                    level[i] <= '0;
                else if (bus.btn_speed[i])
                    level[i] <= (level[i] == 4'(LEVELS - 1)) ? '0 : level[i] + 4'd1;

                if (ramp_step) begin
                    if (cur_duty[i] < target[i])      cur_duty[i] <= cur_duty[i] + 1'b1;
                    else if (cur_duty[i] > target[i]) cur_duty[i] <= cur_duty[i] - 1'b1;
                end

                // Only pick up a new duty at the period boundary to avoid runt pulses.
                if (pwm_wrap) eff_duty[i] <= cur_duty[i];
                pwm_q[i] <= (pwm_cnt < eff_duty[i]);
            end
        end
    end

    // Off-timer FSM with registered sel/sec/timeout outputs.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state   <= IDLE;
            tmr_sel <= '0;
            tmr_sec <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.btn_timer) begin
                        tmr_sel <= 2'd1;
                        tmr_sec <= TMR_W'(TMR_STEP_S);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.btn_timer) begin
                        if (tmr_sel == 2'd3) begin
                            tmr_sel <= '0;
                            tmr_sec <= '0;
                            state   <= IDLE;
                        end else begin
                            tmr_sel <= sel_inc;
                            tmr_sec <= TMR_W'(sel_inc) * TMR_W'(TMR_STEP_S);
                        end
                    end else if (expire) begin
                        tmr_sel <= '0;
                        tmr_sec <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else if (sec_tick) begin
                        tmr_sec <= tmr_sec - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and pin outputs.
    for (genvar g = 0; g < NCH; g++) begin : g_level
        assign bus.level_o[4*g +: 4] = level[g];
    end
    assign bus.pwm_out = pwm_q;
    assign bus.tmr_sel = tmr_sel;
    assign bus.tmr_sec = tmr_sec;
    assign bus.timeout = timeout;
endmodule
